rst_sequencer: RTL and testbench



---
 rtl/rst_sequencer.sv | 112 +++++++++++
 tb/tb_rst_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Staged reset release: turns one synchronous reset into per-stage resets
// released in index order, with a soft-reset request that re-runs the sequence.
module rst_sequencer #(
  parameter int NUM_STAGES      = 3,
  parameter int MIN_ASSERT_CLKS = 4,
  parameter int STAGE_GAP_CLKS  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_sync_rst,
  input  logic                  i_soft_rst_req,
  output logic [NUM_STAGES-1:0] o_stage_rst,
  output logic                  o_all_ready,
  output logic                  o_soft_rst_ack
);

  localparam int CMAX = (MIN_ASSERT_CLKS > STAGE_GAP_CLKS) ?
                        MIN_ASSERT_CLKS : STAGE_GAP_CLKS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    READY
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  req_q;

  // Next-state: soft request acts as a level reset, otherwise count clean edges
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ready_d = ready_q;
    ack_d   = i_soft_rst_req & ~req_q;
    cnt_inc = (cnt_q == CW'(CMAX)) ? cnt_q : cnt_q + 1'b1;
    if (i_soft_rst_req) begin
      stage_d = '1;
      ready_d = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
      state_d = HOLD;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == CW'(MIN_ASSERT_CLKS - 1)) begin
            stage_d[0] = 1'b0;
            cnt_d      = '0;
            idx_d      = IW'(1);
            state_d    = RELEASE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RELEASE: begin
          if (cnt_q == CW'(STAGE_GAP_CLKS - 1)) begin
            cnt_d = '0;
            if (idx_q < IW'(NUM_STAGES)) begin
              for (int i = 0; i < NUM_STAGES; i++)
                if (idx_q == IW'(i)) stage_d[i] = 1'b0;
              idx_d = idx_q + 1'b1;
            end else begin
              ready_d = 1'b1;
              state_d = READY;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        READY: begin
          state_d = READY;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  // State and output registers; external reset overrides everything
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '1;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      req_q   <= i_soft_rst_req;
    end
  end

  assign o_stage_rst    = stage_q;
  assign o_all_ready    = ready_q;
  assign o_soft_rst_ack = ack_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Vector-table bench for rst_sequencer: default build plus a
// minimum-parameter build sharing the clock.
module tb_rst_sequencer;

  typedef struct {
    logic       rst;
    logic       req;
    logic [2:0] stg;
    logic       rdy;
    logic       ack;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, req;
  logic [2:0] stg;
  logic       rdy, ack;
  logic       rst1, req1;
  logic [0:0] stg1;
  logic       rdy1, ack1;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  rst_sequencer #(
    .NUM_STAGES(3), .MIN_ASSERT_CLKS(4), .STAGE_GAP_CLKS(2)
  ) u_dut (
    .i_clk(clk), .i_sync_rst(rst), .i_soft_rst_req(req),
    .o_stage_rst(stg), .o_all_ready(rdy), .o_soft_rst_ack(ack)
  );

  rst_sequencer #(
    .NUM_STAGES(1), .MIN_ASSERT_CLKS(1), .STAGE_GAP_CLKS(1)
  ) u_min (
    .i_clk(clk), .i_sync_rst(rst1), .i_soft_rst_req(req1),
    .o_stage_rst(stg1), .o_all_ready(rdy1), .o_soft_rst_ack(ack1)
  );

  function automatic void add(logic r, logic q, logic [2:0] s,
                              logic y, logic a);
    vec_t v;
    v.rst = r; v.req = q; v.stg = s; v.rdy = y; v.ack = a;
    tbl.push_back(v);
  endfunction

  // Ten clean edges after a reset/request: 4/6/8 releases, ready at 10
  function automatic void add_clean10();
    logic [2:0] s;
    for (int e = 1; e <= 10; e++) begin
      s = (e < 4) ? 3'b111 : (e < 6) ? 3'b110 : (e < 8) ? 3'b100 : 3'b000;
      add(1'b0, 1'b0, s, (e >= 10), 1'b0);
    end
  endfunction

  task automatic chk(string nm, logic [2:0] act, logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step1(logic r, logic q, logic s, logic y, logic a,
                       string nm);
    rst1 = r; req1 = q;
    @(posedge clk); #1;
    chk({nm, " stg"}, {2'b0, stg1}, {2'b0, s});
    chk({nm, " rdy"}, {2'b0, rdy1}, {2'b0, y});
    chk({nm, " ack"}, {2'b0, ack1}, {2'b0, a});
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; rst1 = 1'b1; req1 = 1'b0;

    // power-up
    add(1, 0, 3'b111, 0, 0);
    add(1, 0, 3'b111, 0, 0);
    add_clean10();
    add(0, 0, 3'b000, 1, 0);
    // single-cycle soft request in READY
    add(0, 1, 3'b111, 0, 1);
    add_clean10();
    // held soft request for 5 cycles
    add(0, 1, 3'b111, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 3'b111, 0, 0);
    add_clean10();
    // re-reset one cycle after stage 0 falls
    add(0, 1, 3'b111, 0, 1);
    add(0, 0, 3'b111, 0, 0);
    add(0, 0, 3'b111, 0, 0);
    add(0, 0, 3'b111, 0, 0);
    add(0, 0, 3'b110, 0, 0);
    add(1, 0, 3'b111, 0, 0);
    add_clean10();
    // reset and request together
    add(1, 1, 3'b111, 0, 0);
    add(1, 1, 3'b111, 0, 0);
    add(0, 1, 3'b111, 0, 1);
    add(0, 1, 3'b111, 0, 0);
    add_clean10();

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; req = tbl[i].req;
      @(posedge clk); #1;
      chk($sformatf("v%0d stg", i), stg, tbl[i].stg);
      chk($sformatf("v%0d rdy", i), {2'b0, rdy}, {2'b0, tbl[i].rdy});
      chk($sformatf("v%0d ack", i), {2'b0, ack}, {2'b0, tbl[i].ack});
    end

    // minimum-parameter corner: release after edge 1, ready after edge 2
    step1(1, 0, 1, 0, 0, "min rst");
    step1(0, 0, 0, 0, 0, "min e1");
    step1(0, 0, 0, 1, 0, "min e2");
    step1(0, 0, 0, 1, 0, "min hold");
    step1(0, 1, 1, 0, 1, "min soft");
    step1(0, 0, 0, 0, 0, "min s1");
    step1(0, 0, 0, 1, 0, "min s2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
